cache_simulator: RTL and testbench
==================================

// Module: cache_simulator
// PURPOSE
//  Behavioural-synthesizable cache hit/miss model for address-trace studies. One lookup per
//  clock on the presented byte address into a set-associative, true-LRU tag store (no data).
//  Keeps running 31-bit hit and miss counts for hit-ratio reporting by the surrounding bench.
// PARAMETERS
//  ADDR_W       31  byte-address width
//  CNT_W        31  width of each counter output
//  OFFSET_BITS  6   log2(line size in bytes), so 64 B lines
//  INDEX_BITS   7   log2(number of sets), so 128 sets
//  WAYS         4   associativity; must be a power of two and at least 2
//  TAG_W        ADDR_W-INDEX_BITS-OFFSET_BITS (18), derived; not overridable
// PORTS (positional order is fixed: address, clock, reset, cachemiss, cachehits)
//  clock      in   1      single clock; all state updates on its rising edge
//  reset      in   1      asynchronous, active-low reset
//  address    in   31     byte address of this cycle's access
//  cachemiss  out  31     number of misses since reset
//  cachehits  out  31     number of hits since reset
// BEHAVIOUR
//  - Reset (reset==0, async): all valid bits, tags and LRU ages cleared; cachemiss=0, cachehits=0.
//    Holds while low; accesses resume on the first rising edge with reset==1.
//  - Address split: offset=address[5:0] (ignored), index=address[12:6], tag=address[30:13].
//  - Every rising edge with reset==1 is exactly one access using the address sampled at that edge.
//    No enable and no handshake exist, and the access stream never stalls.
//  - Hit: some way in set[index] has valid=1 and a matching tag. That way becomes MRU, and
//    cachehits increments on the same edge.
//  - Miss: victim = lowest-numbered invalid way; otherwise the LRU way. Victim is written with
//    valid=1 and the new tag and becomes MRU; cachemiss increments on the same edge.
//  - Latency: counters are registered. Values after edge k include access k. Lookup logic is
//    combinational from the address and the current tag store.
//  - LRU: per-way age of log2(WAYS) bits; within a set, ages are a permutation 0..WAYS-1.
//    0 = MRU, WAYS-1 = LRU. On touch of way w, ways with age < age[w] increment and age[w]
//    becomes 0. After reset, ages are initialised to the way number.
//  - Counters saturate at 2^31-1 and do not wrap. Exactly one counter changes per access.
//  - Repeated address, or a different offset within the same line: hit after the first fill.
//  - Address X/Z: no access is counted, the tag store and both counters hold, and a sim-only
//    assertion reports it.
//  - Reset asserted mid-stream: the state is discarded immediately; no partial update is kept.
// STRUCTURE
//  - cache_sim_pkg: ADDR_W, CNT_W, OFFSET_BITS, INDEX_BITS, WAYS, TAG_W and LRU_W=$clog2(WAYS)
//    constants, plus typedefs tag_t, idx_t, age_t and way_t (a struct with valid, tag and age).
//  - Sub-module cache_lru_set: one set's tag compare, victim select and age update. Outputs are
//    hit, hit_way and victim_way. The top holds the set arrays, muxes the set by index and owns
//    both counters.
// TESTING
//  1. Reset low then high with no accesses -> cachemiss=0, cachehits=0.
//  2. Addresses 0x0, 0x4, 0x3F, 0x40 on consecutive edges -> miss=2, hit=2.
//  3. Five distinct tags into set 0 (0x0, 0x2000, 0x4000, 0x6000, 0x8000), then 0x0
//     -> 0x0 was LRU and is evicted, so the final access misses: miss=6, hit=0.
//  4. 0x0, 0x2000, 0x4000, 0x6000, 0x0 (0x0 now MRU), 0x8000 (evicts 0x2000), 0x0, 0x2000
//     -> miss=6, hit=2.
//  5. Sequential-stride trace of 0..0x1FFF step 4, repeated twice (all 128 sets, one line per
//     set) -> miss=128, hit=3968, hit ratio=96.88%.
//  6. Reset pulsed low mid-stream, then a repeat of the last address -> counters 0 during reset,
//     then miss=1, hit=0.

Source files
------------

// File: rtl/cache_sim_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_sim_pkg
// Brief   : Geometry constants and tag-store types for the cache hit/miss model.
// Revision: 1.0
// ============================================================================
package cache_sim_pkg;

  localparam int ADDR_W      = 31;
  localparam int CNT_W       = 31;
  localparam int OFFSET_BITS = 6;
  localparam int INDEX_BITS  = 7;
  localparam int WAYS        = 4;
  localparam int TAG_W       = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int LRU_W       = $clog2(WAYS);
  localparam int SETS        = 1 << INDEX_BITS;

  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [LRU_W-1:0]      age_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
    age_t age;
  } way_t;

  typedef way_t [WAYS-1:0] set_t;

endpackage : cache_sim_pkg
`default_nettype wire

// File: rtl/cache_lru_set.sv
`default_nettype none
// ============================================================================
// Module  : cache_lru_set
// Brief   : One set's tag compare, victim selection and true-LRU age update.
// Revision: 1.0
// ============================================================================
module cache_lru_set
  import cache_sim_pkg::*;
(
  input  logic             [WAYS*$bits(way_t)-1:0] set_cur,
  input  logic             [TAG_W-1:0]             tag,
  output logic                                     hit,
  output logic             [LRU_W-1:0]             hit_way,
  output logic             [LRU_W-1:0]             victim_way,
  output logic             [WAYS*$bits(way_t)-1:0] set_next
);

  localparam age_t c_lru_age = age_t'(WAYS - 1);

  set_t w_cur;
  set_t w_nxt;
  age_t w_touch_way;
  age_t w_touch_age;

  assign w_cur    = set_t'(set_cur);
  assign set_next = w_nxt;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && w_cur[w].valid && (w_cur[w].tag == tag)) begin
        hit     = 1'b1;
        hit_way = age_t'(w);
      end
    end
  end

  // Lowest invalid way wins over the LRU way; the descending scan gives it priority.
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_cur[w].age == c_lru_age) victim_way = age_t'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_cur[w].valid) victim_way = age_t'(w);
    end
  end

  assign w_touch_way = hit ? hit_way : victim_way;
  assign w_touch_age = w_cur[w_touch_way].age;

  always_comb begin
    w_nxt = w_cur;
    for (int w = 0; w < WAYS; w++) begin
      if (age_t'(w) == w_touch_way) begin
        w_nxt[w].age = '0;
        if (!hit) begin
          w_nxt[w].valid = 1'b1;
          w_nxt[w].tag   = tag;
        end
      end else if (w_cur[w].age < w_touch_age) begin
        w_nxt[w].age = w_cur[w].age + age_t'(1);
      end
    end
  end

endmodule : cache_lru_set
`default_nettype wire

// File: rtl/cache_simulator.sv
`default_nettype none
// ============================================================================
// Module  : cache_simulator
// Brief   : Set-associative true-LRU tag store with saturating hit/miss counters.
// Revision: 1.0
// ============================================================================
module cache_simulator
  import cache_sim_pkg::*;
(
  input  logic [ADDR_W-1:0] address,
  input  logic              clock,
  input  logic              reset,
  output logic [CNT_W-1:0]  cachemiss,
  output logic [CNT_W-1:0]  cachehits
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  set_t             r_sets [SETS];
  logic [CNT_W-1:0] r_miss;
  logic [CNT_W-1:0] r_hits;

  idx_t             w_index;
  tag_t             w_tag;
  logic             w_addr_ok;
  logic             w_hit;
  logic [LRU_W-1:0] w_hit_way;
  logic [LRU_W-1:0] w_victim_way;
  set_t             w_next_set;

  assign w_index = address[OFFSET_BITS +: INDEX_BITS];
  assign w_tag   = address[ADDR_W-1 -: TAG_W];

`ifndef SYNTHESIS
  assign w_addr_ok = !$isunknown(address);

  always @(posedge clock) begin
    if (reset) begin
      assert (!$isunknown(address))
        else $error("cache_simulator: address is X/Z, access dropped");
    end
  end
`else
  assign w_addr_ok = 1'b1;
`endif

  cache_lru_set u_set (
    .set_cur    (r_sets[w_index]),
    .tag        (w_tag),
    .hit        (w_hit),
    .hit_way    (w_hit_way),
    .victim_way (w_victim_way),
    .set_next   (w_next_set)
  );

  // Ages start as the way number so each set holds a valid LRU permutation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_sets[s][w] <= '{valid: 1'b0, tag: '0, age: age_t'(w)};
        end
      end
      r_miss <= '0;
      r_hits <= '0;
    end else if (w_addr_ok) begin
      r_sets[w_index] <= w_next_set;
      if (w_hit) begin
        if (r_hits != c_cnt_max) r_hits <= r_hits + 1'b1;
      end else begin
        if (r_miss != c_cnt_max) r_miss <= r_miss + 1'b1;
      end
    end
  end

  assign cachemiss = r_miss;
  assign cachehits = r_hits;

endmodule : cache_simulator
`default_nettype wire

// File: tb/tb_cache_simulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_simulator
// Brief   : Directed and random address traces against an MRU-ordered list model.
// Revision: 1.0
// ============================================================================
module tb_cache_simulator;

  localparam int c_ways = 4;

  logic        clock_10;
  logic        reset;
  logic [30:0] address;
  logic [30:0] cachemiss;
  logic [30:0] cachehits;

  int n_checks;
  int n_errors;

  // Model: per set, a list of resident tags ordered most- to least-recently used.
  int unsigned mdl_q [128][$];
  int unsigned mdl_miss;
  int unsigned mdl_hits;

  cache_simulator dut (
    .address   (address),
    .clock     (clock_10),
    .reset     (reset),
    .cachemiss (cachemiss),
    .cachehits (cachehits)
  );

  initial clock_10 = 1'b0;
  always #5 clock_10 = ~clock_10;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic mdl_clear();
    for (int s = 0; s < 128; s++) mdl_q[s].delete();
    mdl_miss = 0;
    mdl_hits = 0;
  endtask

  task automatic mdl_access(input logic [30:0] a);
    int unsigned idx;
    int unsigned tg;
    int          pos;
    idx = int'(a / 64) % 128;
    tg  = int'(a / 8192);
    pos = -1;
    for (int i = 0; i < mdl_q[idx].size(); i++) begin
      if (mdl_q[idx][i] == tg) pos = i;
    end
    if (pos >= 0) begin
      mdl_q[idx].delete(pos);
      mdl_hits++;
    end else begin
      if (mdl_q[idx].size() == c_ways) void'(mdl_q[idx].pop_back());
      mdl_miss++;
    end
    mdl_q[idx].push_front(tg);
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic access(input logic [30:0] a, input bit chk);
    address = a;
    @(posedge clock_10);
    mdl_access(a);
    @(negedge clock_10);
    if (chk) begin
      check("miss", {1'b0, cachemiss}, mdl_miss);
      check("hits", {1'b0, cachehits}, mdl_hits);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mdl_clear();
    repeat (2) @(negedge clock_10);
    check("rst_miss", {1'b0, cachemiss}, 32'd0);
    check("rst_hits", {1'b0, cachehits}, 32'd0);
    reset = 1'b1;
  endtask

  task automatic check_final(input string tg, input int m, input int h);
    check({tg, "_miss"}, {1'b0, cachemiss}, m);
    check({tg, "_hits"}, {1'b0, cachehits}, h);
  endtask

  logic [30:0] t3 [6];
  logic [30:0] t4 [8];
  logic [30:0] last_addr;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    address  = '0;
    t3 = '{31'h0, 31'h2000, 31'h4000, 31'h6000, 31'h8000, 31'h0};
    t4 = '{31'h0, 31'h2000, 31'h4000, 31'h6000, 31'h0, 31'h8000, 31'h0, 31'h2000};
    @(negedge clock_10);

    // Reset with no accesses: counters stay zero; release then idle at reset low again.
    do_reset();
    check_final("t1", 0, 0);

    do_reset();
    access(31'h0, 1); access(31'h4, 1); access(31'h3F, 1); access(31'h40, 1);
    check_final("t2", 2, 2);

    do_reset();
    foreach (t3[i]) access(t3[i], 1);
    check_final("t3", 6, 0);

    do_reset();
    foreach (t4[i]) access(t4[i], 1);
    check_final("t4", 6, 2);

    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 32'h2000; a += 4) access(31'(a), 0);
    end
    check_final("t5", 128, 3968);
    check("t5_mdl_miss", {1'b0, cachemiss}, mdl_miss);

    // Random trace over few sets and few tags so hits, misses and evictions all occur.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      last_addr = {28'($urandom_range(0, 6)), 3'b000} << 10;
      last_addr = 31'({$urandom_range(0, 6), 13'h0}) |
                  31'({$urandom_range(0, 3), 6'h0}) |
                  31'($urandom_range(0, 63));
      access(last_addr, 1);
    end

    // Reset pulsed asynchronously between edges, then the last address repeats.
    #2 reset = 1'b0;
    #1;
    check("t6_async_miss", {1'b0, cachemiss}, 32'd0);
    check("t6_async_hits", {1'b0, cachehits}, 32'd0);
    mdl_clear();
    @(negedge clock_10);
    check("t6_hold_miss", {1'b0, cachemiss}, 32'd0);
    reset = 1'b1;
    access(last_addr, 1);
    check_final("t6", 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_cache_simulator
`default_nettype wire
